pmod_butled_ctrl: RTL and testbench

- Memory-mapped controller for the 4-button / 4-LED PMOD on the board pio header.
- Synchronises and debounces the raw buttons, and latches press/release events with W1C clear.
- Raises an interrupt on enabled presses and drives the LEDs with per-LED 8-bit PWM brightness or a hardware echo of the buttons.
- Sits between the SoC peripheral bus (IPORT/OPORT decode region) and the PMOD pin adapter.

---
 rtl/pmod_butled_ctrl.sv | 149 ++++++++++++++
 tb/tb_pmod_butled_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pmod_butled_ctrl.sv
// 4-button / 4-LED PMOD controller: sync, debounce, W1C events, irq, PWM/echo LEDs.
// Ports: clk, reset (async active-low), wr/rd/addr/wdata/rdata bus, irq, btn_raw in, led_out.
module pmod_butled_ctrl #(
  parameter int DEBOUNCE_CYC = 50000,
  parameter int PWM_BITS     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic        rd,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  input  logic [3:0]  btn_raw,
  output logic [3:0]  led_out
);

  localparam int CW = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  localparam logic [1:0] A_STATUS = 2'd0;
  localparam logic [1:0] A_EVENT  = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam logic [1:0] A_DUTY   = 2'd3;

  logic [3:0]          sync1;
  logic [3:0]          sbtn;
  logic [3:0]          stable;
  logic [CW-1:0]       cnt [4];
  logic [CW-1:0]       cnt_nx [4];
  logic [3:0]          upd;
  logic [3:0]          press_set;
  logic [3:0]          rel_set;
  logic [3:0]          evt_press;
  logic [3:0]          evt_rel;
  logic [4:0]          ctrl;
  logic [31:0]         duty;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [3:0]          led_pwm;
  logic [3:0]          clr_press;
  logic [3:0]          clr_rel;
  logic                wr_evt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sbtn  <= '0;
    end else begin
      sync1 <= btn_raw;
      sbtn  <= sync1;
    end
  end

  // A level is accepted only after the counter has seen it differ
  // for DEBOUNCE_CYC consecutive cycles.
  always_comb begin
    upd = '0;
    for (int i = 0; i < 4; i++) begin
      cnt_nx[i] = '0;
      if (sbtn[i] != stable[i]) begin
        if (cnt[i] == CNT_MAX) begin
          upd[i] = 1'b1;
        end else begin
          cnt_nx[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  assign press_set = upd & sbtn;
  assign rel_set   = upd & ~sbtn;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      stable <= (stable & ~upd) | (sbtn & upd);
      for (int i = 0; i < 4; i++) cnt[i] <= cnt_nx[i];
    end
  end

  assign wr_evt    = wr && (addr == A_EVENT);
  assign clr_press = wr_evt ? wdata[3:0] : 4'd0;
  assign clr_rel   = wr_evt ? wdata[7:4] : 4'd0;

  // Hardware set is OR-ed after the clear, so set wins a tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      evt_press <= '0;
      evt_rel   <= '0;
    end else begin
      evt_press <= (evt_press & ~clr_press) | press_set;
      evt_rel   <= (evt_rel & ~clr_rel) | rel_set;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl <= '0;
      duty <= '0;
    end else if (wr) begin
      if (addr == A_CTRL) ctrl <= wdata[4:0];
      if (addr == A_DUTY) duty <= wdata;
    end
  end

  // Reads sample the registers before any same-cycle write lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (rd) begin
      unique case (addr)
        A_STATUS: rdata <= {28'd0, stable};
        A_EVENT:  rdata <= {24'd0, evt_rel, evt_press};
        A_CTRL:   rdata <= {27'd0, ctrl};
        A_DUTY:   rdata <= duty;
        default:  rdata <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq <= 1'b0;
    end else begin
      irq <= |(evt_press & ctrl[3:0]);
    end
  end

  always_comb begin
    led_pwm = '0;
    for (int i = 0; i < 4; i++) begin
      led_pwm[i] = pwm_cnt < duty[8*i +: PWM_BITS];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_cnt <= '0;
      led_out <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      led_out <= ctrl[4] ? stable : led_pwm;
    end
  end

endmodule

// File: tb/tb_pmod_butled_ctrl.sv
// Scoreboard bench for pmod_butled_ctrl: reads queue expectations, monitor compares.
// Direct checks cover irq, async reset and LED duty counts.
module tb_pmod_butled_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr;
  logic        rd;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  logic [3:0]  btn_raw;
  logic [3:0]  led_out;

  int n_vec = 0;
  int n_err = 0;

  logic [33:0] exp_q [$];
  logic [33:0] ent;
  logic        rd_q = 1'b0;
  int          lcnt [4];
  int          bad;

  always #5 clk = ~clk;

  pmod_butled_ctrl #(
    .DEBOUNCE_CYC(16),
    .PWM_BITS(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr(wr),
    .rd(rd),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .irq(irq),
    .btn_raw(btn_raw),
    .led_out(led_out)
  );

  always @(posedge clk) rd_q <= rd;

  always @(negedge clk) begin
    if (rd_q) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_underflow got=%h required=none", rdata);
      end else begin
        ent = exp_q.pop_front();
        if (rdata !== ent[31:0]) begin
          n_err++;
          $display("FAIL rd addr=%0d got=%h required=%h",
                   ent[33:32], rdata, ent[31:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h required=%h", nm, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    wr = 1'b1;
    addr = a;
    wdata = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, input logic [31:0] e);
    rd = 1'b1;
    addr = a;
    exp_q.push_back({a, e});
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic count_leds(input int n);
    for (int j = 0; j < 4; j++) lcnt[j] = 0;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 4; j++) lcnt[j] += int'(led_out[j]);
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    wr = 1'b0;
    rd = 1'b0;
    addr = 2'd0;
    wdata = '0;
    btn_raw = 4'd0;
    idle(3);
    reset = 1'b1;
    idle(1);
    for (int a = 0; a < 4; a++) bus_rd(2'(a), 32'h0);

    // async reset with buttons pressed, duty set, irq up
    bus_wr(2'd3, 32'hFFFF_FFFF);
    bus_wr(2'd2, 32'h0000_000F);
    btn_raw = 4'hF;
    idle(25);
    chk("irq_pre_reset", {31'd0, irq}, 32'd1);
    bus_rd(2'd3, 32'hFFFF_FFFF);
    #3;
    reset = 1'b0;
    btn_raw = 4'h0;
    #1;
    chk("rst_led", {28'd0, led_out}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(negedge clk);
    idle(2);
    reset = 1'b1;
    idle(1);
    for (int a = 0; a < 4; a++) bus_rd(2'(a), 32'h0);

    // 15-cycle glitch is rejected
    btn_raw[0] = 1'b1;
    idle(15);
    btn_raw[0] = 1'b0;
    idle(30);
    bus_rd(2'd0, 32'h0);
    bus_rd(2'd1, 32'h0);

    // held press: stable updates on edge 18 after the rise
    btn_raw[0] = 1'b1;
    idle(17);
    bus_rd(2'd0, 32'h0);
    bus_rd(2'd0, 32'h1);
    bus_rd(2'd1, 32'h01);

    // interrupt and W1C
    btn_raw[0] = 1'b0;
    idle(25);
    chk("irq_disabled", {31'd0, irq}, 32'd0);
    bus_wr(2'd2, 32'h1);
    idle(2);
    chk("irq_enabled", {31'd0, irq}, 32'd1);
    bus_rd(2'd1, 32'h11);
    bus_wr(2'd1, 32'h01);
    chk("irq_lag", {31'd0, irq}, 32'd1);
    idle(1);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    bus_rd(2'd1, 32'h10);

    // W1C on the same edge as a new press: set wins
    btn_raw[0] = 1'b1;
    idle(17);
    bus_wr(2'd1, 32'h01);
    bus_rd(2'd1, 32'h11);
    chk("irq_set_wins", {31'd0, irq}, 32'd1);
    btn_raw[0] = 1'b0;
    idle(25);
    bus_wr(2'd1, 32'hFF);
    bus_wr(2'd2, 32'h0);
    bus_rd(2'd1, 32'h0);

    // PWM duty counts over one full period
    bus_wr(2'd3, 32'hFF80_4000);
    idle(2);
    count_leds(256);
    chk("pwm_led0", 32'(lcnt[0]), 32'd0);
    chk("pwm_led1", 32'(lcnt[1]), 32'd64);
    chk("pwm_led2", 32'(lcnt[2]), 32'd128);
    chk("pwm_led3", 32'(lcnt[3]), 32'd255);

    // echo mode overrides PWM
    btn_raw = 4'b1010;
    idle(25);
    bus_wr(2'd2, 32'h10);
    idle(1);
    chk("echo_led", {28'd0, led_out}, 32'hA);
    bad = 0;
    for (int k = 0; k < 256; k++) begin
      if (led_out !== 4'b1010) bad++;
      @(negedge clk);
    end
    chk("echo_hold", 32'(bad), 32'd0);
    bus_wr(2'd2, 32'h0);
    idle(1);
    count_leds(256);
    chk("resume_led1", 32'(lcnt[1]), 32'd64);
    chk("resume_led3", 32'(lcnt[3]), 32'd255);

    // read timing and register masking
    bus_wr(2'd2, 32'hFFFF_FFE3);
    bus_rd(2'd2, 32'h03);
    rd = 1'b1;
    wr = 1'b1;
    addr = 2'd2;
    wdata = 32'h1F;
    exp_q.push_back({2'd2, 32'h03});
    @(negedge clk);
    rd = 1'b0;
    wr = 1'b0;
    bus_rd(2'd2, 32'h1F);
    bus_wr(2'd0, 32'hF);
    bus_rd(2'd0, 32'hA);
    bus_rd(2'd3, 32'hFF80_4000);

    btn_raw = 4'd0;
    idle(3);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain got=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
